gpio_stream_bridge: RTL

Parametrised bridge between the processor GPIO block and the convolution accelerator. It replaces the bit-banged io_clk/wr/rd scheme with a toggle-strobe/ack command protocol that is synchronised into Clk. It also adds internal tagged input and output FIFOs, multi-channel addressing and sticky error reporting. The processor BD instantiates it between the GPIO ports and the accelerator core.

---
 rtl/gpio_stream_bridge.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_stream_bridge.sv
// GPIO-to-accelerator bridge: toggle-strobe/ack command channel synchronised into Clk,
// tagged FWFT input FIFO toward the accelerator, result FIFO back to GPIO, sticky errors.
module gpio_stream_bridge #(
  parameter int DATA_W    = 16,
  parameter int CHANNELS  = 4,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              gpio_strobe,
  input  logic              gpio_wr,
  input  logic              gpio_rd,
  input  logic              gpio_clr,
  input  logic              gpio_newline,
  input  logic [CH_W-1:0]   gpio_chan_sel,
  input  logic [DATA_W-1:0] gpio_data_in,
  input  logic              gpio_start,
  output logic              gpio_ack,
  output logic [DATA_W-1:0] gpio_data_out,
  output logic [CH_W-1:0]   gpio_chan_out,
  output logic [5:0]        gpio_status,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [DATA_W-1:0] acc_data,
  output logic [CH_W-1:0]   acc_chan,
  output logic              acc_newline,
  output logic              acc_start,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [CH_W-1:0]   res_chan,
  output logic [1:0]        dbg_state_o
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int IN_W   = 1 + CH_W + DATA_W;
  localparam int OUT_W  = CH_W + DATA_W;
  localparam logic [IN_AW:0]  IN_FULL_CNT  = (IN_AW + 1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL_CNT = (OUT_AW + 1)'(OUT_DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_ACK = 2'd2} state_e;

  // Handshake: the processor changes gpio_strobe once per command and holds the command
  // fields stable until gpio_ack changes; acc_* and res_* move a word when valid && ready.
  state_e              state_q;
  logic                strb_s1_q, strb_s2_q, strb_s3_q;
  logic                cmd_wr_q, cmd_rd_q, cmd_clr_q, cmd_nl_q;
  logic [CH_W-1:0]     cmd_chan_q;
  logic [DATA_W-1:0]   cmd_data_q;
  logic                gpio_ack_q, err_ovf_q, err_udf_q;
  logic [DATA_W-1:0]   gpio_data_out_q;
  logic [CH_W-1:0]     gpio_chan_out_q;
  logic [3:0]          start_sh_q;
  logic                acc_start_q;

  logic [IN_W-1:0]     in_mem [IN_DEPTH];
  logic [IN_AW-1:0]    in_wptr_q, in_rptr_q;
  logic [IN_AW:0]      in_cnt_q, in_cnt_d;
  logic                in_full_q, in_empty_q;
  logic [OUT_W-1:0]    out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0]   out_wptr_q, out_rptr_q;
  logic [OUT_AW:0]     out_cnt_q, out_cnt_d;
  logic                out_full_q, out_empty_q;

  logic pending, exec, in_pop, in_push, out_pop, out_push;
  logic [IN_W-1:0]  in_head;
  logic [OUT_W-1:0] out_head;

  assign pending  = strb_s2_q ^ strb_s3_q;
  assign exec     = (state_q == ST_EXEC);
  assign in_pop   = !in_empty_q && acc_ready;
  assign in_push  = exec && cmd_wr_q && (!in_full_q || in_pop);
  assign out_push = res_valid && !out_full_q;
  assign out_pop  = exec && cmd_rd_q && !out_empty_q;
  assign in_head  = in_mem[in_rptr_q];
  assign out_head = out_mem[out_rptr_q];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q         <= ST_IDLE;
      strb_s1_q       <= 1'b0;
      strb_s2_q       <= 1'b0;
      strb_s3_q       <= 1'b0;
      cmd_wr_q        <= 1'b0;
      cmd_rd_q        <= 1'b0;
      cmd_clr_q       <= 1'b0;
      cmd_nl_q        <= 1'b0;
      cmd_chan_q      <= '0;
      cmd_data_q      <= '0;
      gpio_ack_q      <= 1'b0;
      err_ovf_q       <= 1'b0;
      err_udf_q       <= 1'b0;
      gpio_data_out_q <= '0;
      gpio_chan_out_q <= '0;
    end else begin
      strb_s1_q <= gpio_strobe;
      strb_s2_q <= strb_s1_q;
      case (state_q)
        ST_IDLE: begin
          strb_s3_q <= strb_s2_q;
          if (pending) begin
            state_q    <= ST_EXEC;
            cmd_wr_q   <= gpio_wr;
            cmd_rd_q   <= gpio_rd;
            cmd_clr_q  <= gpio_clr;
            cmd_nl_q   <= gpio_newline;
            cmd_chan_q <= gpio_chan_sel;
            cmd_data_q <= gpio_data_in;
          end
        end
        ST_EXEC: begin
          // Error assignments come after the clear so a fresh error survives a clr.
          if (cmd_clr_q) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
          end
          if (cmd_wr_q && !in_push) err_ovf_q <= 1'b1;
          if (cmd_rd_q) begin
            if (out_pop) begin
              gpio_data_out_q <= out_head[DATA_W-1:0];
              gpio_chan_out_q <= out_head[OUT_W-1:DATA_W];
            end else begin
              err_udf_q <= 1'b1;
            end
          end
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          gpio_ack_q <= ~gpio_ack_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_cnt_d  = in_cnt_q + (IN_AW + 1)'(in_push) - (IN_AW + 1)'(in_pop);
    out_cnt_d = out_cnt_q + (OUT_AW + 1)'(out_push) - (OUT_AW + 1)'(out_pop);
  end

  always_ff @(posedge Clk) begin
    if (in_push)  in_mem[in_wptr_q]   <= {cmd_nl_q, cmd_chan_q, cmd_data_q};
    if (out_push) out_mem[out_wptr_q] <= {res_chan, res_data};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      in_wptr_q   <= '0;
      in_rptr_q   <= '0;
      in_cnt_q    <= '0;
      in_full_q   <= 1'b0;
      in_empty_q  <= 1'b1;
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_cnt_q   <= '0;
      out_full_q  <= 1'b0;
      out_empty_q <= 1'b1;
    end else begin
      if (in_push)  in_wptr_q  <= in_wptr_q + IN_AW'(1);
      if (in_pop)   in_rptr_q  <= in_rptr_q + IN_AW'(1);
      if (out_push) out_wptr_q <= out_wptr_q + OUT_AW'(1);
      if (out_pop)  out_rptr_q <= out_rptr_q + OUT_AW'(1);
      in_cnt_q    <= in_cnt_d;
      in_full_q   <= (in_cnt_d == IN_FULL_CNT);
      in_empty_q  <= (in_cnt_d == '0);
      out_cnt_q   <= out_cnt_d;
      out_full_q  <= (out_cnt_d == OUT_FULL_CNT);
      out_empty_q <= (out_cnt_d == '0);
    end
  end

  // Two-flop synchroniser followed by a two-stage edge detector for the start level.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      start_sh_q  <= '0;
      acc_start_q <= 1'b0;
    end else begin
      start_sh_q  <= {start_sh_q[2:0], gpio_start};
      acc_start_q <= start_sh_q[2] & ~start_sh_q[3];
    end
  end

  assign gpio_ack      = gpio_ack_q;
  assign gpio_data_out = gpio_data_out_q;
  assign gpio_chan_out = gpio_chan_out_q;
  assign gpio_status   = {err_ovf_q, err_udf_q, out_full_q, out_empty_q, in_full_q, in_empty_q};
  assign acc_valid     = !in_empty_q;
  assign acc_data      = in_head[DATA_W-1:0];
  assign acc_chan      = in_head[DATA_W+CH_W-1:DATA_W];
  assign acc_newline   = in_head[IN_W-1];
  assign acc_start     = acc_start_q;
  assign res_ready     = !out_full_q;
  assign dbg_state_o   = state_q;

endmodule
